// File: rtl/proc72_pkg.sv
// Shared definitions for the 72-bit processor and its program loader.
package proc72_pkg;

    localparam int unsigned WORD_W         = 72;
    localparam int unsigned OPCODE_W       = 4;
    localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone
    } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Shifts bytes MSB-first into a WORD_W-bit register and flags the last byte of a word.
module word_assembler #(
    parameter int unsigned WORD_W = proc72_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    localparam int unsigned NBytes = WORD_W / 8;
    localparam int unsigned CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(NBytes - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0] data_q, data_d;

    // Next-state: shift in a byte, count it, and wrap the counter on the last byte.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        full   = shift_en && (cnt_q == LastIdx);
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en) begin
            data_d = {data_q[WORD_W-9:0], byte_in};
            cnt_d  = full ? '0 : cnt_q + CntW'(1);
        end
    end

    // Byte counter and assembly register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign word = data_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Streams bytes into instruction memory one word at a time, holding the core in reset meanwhile.
module instr_mem_loader #(
    parameter int unsigned WORD_W = proc72_pkg::WORD_W,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import proc72_pkg::*;

    // Largest legal length is a full memory, 2^ADDR_W words.
    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

    loader_state_e   state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] word_q, word_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            asm_clear;
    logic            asm_full;
    logic            shift_en;
    logic [WORD_W-1:0] asm_word;

    assign shift_en = byte_ready && byte_valid;

    word_assembler #(
        .WORD_W (WORD_W)
    ) u_word_assembler (
        .clk      (clk),
        .rst      (rst),
        .clear    (asm_clear),
        .shift_en (shift_en),
        .byte_in  (byte_data),
        .word     (asm_word),
        .full     (asm_full)
    );

    // Next-state logic: start qualification, word sequencing and completion.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        word_d    = word_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        asm_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (load_len == '0) begin
                        done_d = 1'b1;
                    end else if (load_len > MaxLen) begin
                        err_d = 1'b1;
                    end else begin
                        asm_clear = 1'b1;
                        word_d    = '0;
                        len_d     = load_len;
                        state_d   = StRecv;
                    end
                end
            end
            StRecv: begin
                if (asm_full) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                asm_clear = 1'b1;
                word_d    = word_q + (ADDR_W + 1)'(1);
                // Word count is one bit wider than the address, so the last address never wraps.
                state_d   = (word_d == len_q) ? StDone : StRecv;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched length, word counter and registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready = (state_q == StRecv);
    assign mem_we     = (state_q == StWrite);
    assign mem_addr   = word_q[ADDR_W-1:0];
    assign mem_wdata  = asm_word;
    assign busy       = (state_q != StIdle);
    assign cpu_hold   = (state_q != StIdle);
    assign done       = done_q || (state_q == StDone);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: one full-size instance (A) and one ADDR_W=2 instance (B).
module tb_instr_mem_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [71:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [8:0]  len_a;
    logic [2:0]  len_b;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        ready_a, we_a, hold_a, busy_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [71:0] wdata_a;
    logic        ready_b, we_b, hold_b, busy_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [71:0] wdata_b;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt_a = 0, wr_cnt_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    int err_cnt_a = 0, err_cnt_b = 0;

    wr_t q_a[$];
    wr_t q_b[$];
    wr_t exp_a, exp_b;

    always #5 clk = ~clk;

    instr_mem_loader #(
        .WORD_W (72),
        .ADDR_W (8)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .load_len   (len_a),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (ready_a),
        .mem_we     (we_a),
        .mem_addr   (addr_a),
        .mem_wdata  (wdata_a),
        .cpu_hold   (hold_a),
        .busy       (busy_a),
        .done       (done_a),
        .err        (err_a)
    );

    instr_mem_loader #(
        .WORD_W (72),
        .ADDR_W (2)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .load_len   (len_b),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (ready_b),
        .mem_we     (we_b),
        .mem_addr   (addr_b),
        .mem_wdata  (wdata_b),
        .cpu_hold   (hold_b),
        .busy       (busy_b),
        .done       (done_b),
        .err        (err_b)
    );

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst) begin
            if (we_a) begin
                wr_cnt_a++;
                check_eq("ready_low_in_write_a", 80'(ready_a), 80'(0));
                if (q_a.size() == 0) begin
                    check_eq("unexpected_we_a", 80'(we_a), 80'(0));
                end else begin
                    exp_a = q_a.pop_front();
                    check_eq("addr_a", 80'(addr_a), 80'(exp_a.addr));
                    check_eq("data_a", 80'(wdata_a), 80'(exp_a.data));
                end
            end
            if (we_b) begin
                wr_cnt_b++;
                check_eq("ready_low_in_write_b", 80'(ready_b), 80'(0));
                if (q_b.size() == 0) begin
                    check_eq("unexpected_we_b", 80'(we_b), 80'(0));
                end else begin
                    exp_b = q_b.pop_front();
                    check_eq("addr_b", 80'(addr_b), 80'(exp_b.addr));
                    check_eq("data_b", 80'(wdata_b), 80'(exp_b.data));
                end
            end
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
            if (err_a)  err_cnt_a++;
            if (err_b)  err_cnt_b++;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(input bit sel, input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!(sel ? ready_b : ready_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check_eq("ready_timeout", 80'(sel ? ready_b : ready_a), 80'(1));
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input bit sel, input logic [7:0] addr, input logic [71:0] w,
                             input bit gap);
        wr_t e;
        e.addr = addr;
        e.data = w;
        if (sel) q_b.push_back(e);
        else q_a.push_back(e);
        for (int i = 0; i < 9; i++) begin
            if (gap) @(negedge clk);
            send_byte(sel, w[71-8*i -: 8]);
        end
    endtask

    task automatic pulse_start(input bit sel, input logic [8:0] len);
        if (sel) begin
            start_b = 1'b1;
            len_b   = len[2:0];
        end else begin
            start_a = 1'b1;
            len_a   = len;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    function automatic logic [71:0] rand_word();
        logic [31:0] r0, r1, r2;
        r0 = $urandom();
        r1 = $urandom();
        r2 = $urandom();
        return {r0, r1, r2[7:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [71:0] w;
        int          wr_before;

        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        len_a = '0;
        len_b = '0;
        byte_valid = 1'b0;
        byte_data = '0;

        #1;
        check_eq("rst_ready", 80'(ready_a), 80'(0));
        check_eq("rst_we", 80'(we_a), 80'(0));
        check_eq("rst_hold", 80'(hold_a), 80'(0));
        check_eq("rst_busy", 80'(busy_a), 80'(0));
        check_eq("rst_done", 80'(done_a), 80'(0));
        check_eq("rst_err", 80'(err_a), 80'(0));
        check_eq("rst_addr", 80'(addr_a), 80'(0));
        check_eq("rst_wdata", 80'(wdata_a), 80'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single word, back-to-back bytes.
        pulse_start(0, 9'd1);
        check_eq("t1_hold_after_start", 80'(hold_a), 80'(1));
        check_eq("t1_busy_after_start", 80'(busy_a), 80'(1));
        send_word(0, 8'd0, 72'h101112131415161718, 0);
        check_eq("t1_we_after_last_byte", 80'(we_a), 80'(1));
        @(negedge clk);
        check_eq("t1_done", 80'(done_a), 80'(1));
        check_eq("t1_hold_in_done", 80'(hold_a), 80'(1));
        @(negedge clk);
        check_eq("t1_done_cleared", 80'(done_a), 80'(0));
        check_eq("t1_hold_released", 80'(hold_a), 80'(0));
        check_eq("t1_busy_cleared", 80'(busy_a), 80'(0));

        // Three words with the source idle every other cycle.
        pulse_start(0, 9'd3);
        for (int k = 0; k < 3; k++) begin
            w = rand_word();
            send_word(0, 8'(k), w, 1);
        end
        @(negedge clk);
        check_eq("t2_done", 80'(done_a), 80'(1));
        @(negedge clk);
        check_eq("t2_idle", 80'(busy_a), 80'(0));

        // Small memory filled completely; address must not wrap.
        pulse_start(1, 9'd4);
        for (int k = 0; k < 4; k++) begin
            w = rand_word();
            send_word(1, 8'(k), w, 0);
        end
        @(negedge clk);
        check_eq("t3_done", 80'(done_b), 80'(1));
        repeat (5) @(negedge clk);
        check_eq("t3_busy_after", 80'(busy_b), 80'(0));
        check_eq("t3_write_count", 80'(wr_cnt_b), 80'(4));

        // Oversized length on the small memory.
        pulse_start(1, 9'd5);
        check_eq("t4_err", 80'(err_b), 80'(1));
        check_eq("t4_busy", 80'(busy_b), 80'(0));
        @(negedge clk);
        check_eq("t4_err_pulse", 80'(err_b), 80'(0));
        check_eq("t4_busy_after", 80'(busy_b), 80'(0));

        // Zero-length load.
        wr_before = wr_cnt_a;
        pulse_start(0, 9'd0);
        check_eq("t5_done", 80'(done_a), 80'(1));
        check_eq("t5_busy", 80'(busy_a), 80'(0));
        check_eq("t5_err", 80'(err_a), 80'(0));
        @(negedge clk);
        check_eq("t5_done_pulse", 80'(done_a), 80'(0));
        repeat (3) @(negedge clk);
        check_eq("t5_no_write", 80'(wr_cnt_a), 80'(wr_before));

        // Reset in the middle of a word.
        pulse_start(0, 9'd2);
        for (int i = 0; i < 5; i++) send_byte(0, 8'hA0 + 8'(i));
        rst = 1'b0;
        #1;
        check_eq("t6_ready", 80'(ready_a), 80'(0));
        check_eq("t6_we", 80'(we_a), 80'(0));
        check_eq("t6_hold", 80'(hold_a), 80'(0));
        check_eq("t6_busy", 80'(busy_a), 80'(0));
        check_eq("t6_done", 80'(done_a), 80'(0));
        check_eq("t6_err", 80'(err_a), 80'(0));
        check_eq("t6_addr", 80'(addr_a), 80'(0));
        check_eq("t6_wdata", 80'(wdata_a), 80'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start(0, 9'd1);
        send_word(0, 8'd0, 72'hB0B1B2B3B4B5B6B7B8, 0);
        @(negedge clk);
        check_eq("t6_done_after_restart", 80'(done_a), 80'(1));
        @(negedge clk);

        // Start pulsed mid-word must not disturb the running load.
        pulse_start(0, 9'd2);
        w = rand_word();
        exp_a.addr = 8'd0;
        exp_a.data = w;
        q_a.push_back(exp_a);
        for (int i = 0; i < 4; i++) send_byte(0, w[71-8*i -: 8]);
        pulse_start(0, 9'd1);
        check_eq("t7_no_err", 80'(err_a), 80'(0));
        check_eq("t7_still_busy", 80'(busy_a), 80'(1));
        for (int i = 4; i < 9; i++) send_byte(0, w[71-8*i -: 8]);
        @(negedge clk);
        check_eq("t7_not_done_after_word0", 80'(done_a), 80'(0));
        check_eq("t7_recv_again", 80'(ready_a), 80'(1));
        w = rand_word();
        send_word(0, 8'd1, w, 0);
        @(negedge clk);
        check_eq("t7_done", 80'(done_a), 80'(1));

        repeat (4) @(negedge clk);
        check_eq("sb_a_drained", 80'(q_a.size()), 80'(0));
        check_eq("sb_b_drained", 80'(q_b.size()), 80'(0));
        check_eq("done_count_a", 80'(done_cnt_a), 80'(5));
        check_eq("done_count_b", 80'(done_cnt_b), 80'(1));
        check_eq("err_count_a", 80'(err_cnt_a), 80'(0));
        check_eq("err_count_b", 80'(err_cnt_b), 80'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Program loader that fills the 72-bit instruction memory before the processor runs. It receives a byte stream over a valid/ready handshake and assembles each group of 9 bytes, MSB first, into one 72-bit instruction word. It writes each word to sequential instruction-memory addresses starting at 0. While it runs it holds the processor core in reset, and it releases the core once the requested number of words has been written.

## Interface
Parameters:
- `WORD_W`, 72, instruction word width; must be a multiple of 8.
- `ADDR_W`, 8, instruction-memory address width; depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `load_len`  in  ADDR_W+1  number of words to load; sampled together with `start`.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  WORD_W  write data.
- `cpu_hold`  out  1  holds the processor core in reset while high.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  one-cycle pulse when a `start` is rejected.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- Byte order: the first byte accepted fills bits [71:64], which hold the opcode field. The 9th byte fills bits [7:0].
- IDLE:
  - `start` with 1 ≤ `load_len` ≤ 2^ADDR_W: clear the byte counter and word counter, set the address to 0, latch `load_len`, go to RECV.
  - `start` with `load_len` = 0: pulse `done`, stay in IDLE. No write occurs.
  - `start` with `load_len` > 2^ADDR_W: pulse `err`, stay in IDLE.
- RECV:
  - `byte_ready`=1.
  - On `byte_valid`&`byte_ready`, shift the byte into the assembly register and increment the byte counter (0..8).
  - On acceptance of the 9th byte, go to WRITE.
- WRITE:
  - `byte_ready`=0.
  - `mem_we`=1 for exactly one cycle, with `mem_addr` = word counter and `mem_wdata` = the assembled word.
  - Then increment the word counter and clear the byte counter.
  - If words written equals the latched length, go to DONE; otherwise return to RECV.
- DONE: pulse `done` for one cycle, then go to IDLE.
- `cpu_hold` = 1 from the cycle after an accepted `start` through the DONE cycle. It is 0 in the IDLE cycle that follows.
- `start` outside IDLE is ignored, with no `err`.
- The address never wraps. The final word at 2^ADDR_W-1 is followed by DONE, not by address 0.

## Timing
- Reset values:
  - `byte_ready`, `mem_we`, `cpu_hold`, `busy`, `done` and `err` are 0.
  - `mem_addr` and `mem_wdata` are 0.
  - State is IDLE.
- All outputs are registered or decoded directly from state. There is no combinational path from `byte_valid` to `byte_ready`.
- Per-word latency:
  - The word is written in the cycle after the 9th byte handshake.
  - With `byte_valid` held high, a word takes 10 cycles (9 in RECV, 1 in WRITE).
- An idle source (`byte_valid`=0) stalls RECV indefinitely; there is no timeout.
- When `load_len` = 1, `done` asserts 2 cycles after the 9th byte handshake.
- Reset asserted mid-load:
  - Outputs return to reset values immediately (asynchronously).
  - The partial word is discarded and nothing is written.
  - After reset, a new `start` begins again at address 0.

## Structure
- Shared package `proc72_pkg` holds:
  - `WORD_W` = 72 and `OPCODE_W` = 4;
  - `BYTES_PER_WORD` = `WORD_W`/8;
  - the loader state enum.
- Sub-module `word_assembler`: 8-bit to `WORD_W` shift register with byte counter, a `shift_en` input and a `full` flag. Its counter clears on `clear`.
- The FSM, word counter and address register live in `instr_mem_loader`.

## Test plan
- Reset then `start` with `load_len`=1; send bytes 0x10,0x11,…,0x18 back-to-back.
  - Required: one `mem_we` at addr 0 with data 0x101112131415161718.
  - Required: `done` 2 cycles after the last byte; `cpu_hold` low the following cycle.
- `load_len`=3, with `byte_valid` toggled every other cycle.
  - Required: three writes at addrs 0,1,2 with the correct words.
  - Required: no write while `byte_valid`=0 stalls; `byte_ready` is low in each WRITE cycle.
- `ADDR_W`=2, `load_len`=4.
  - Required: writes at addr 0..3, then `done`; no write to addr 0 after addr 3.
- `load_len`=5 with `ADDR_W`=2 → `err` pulse, `busy` stays 0.
- `load_len`=0 → `done` pulse only, no `mem_we`.
- Assert `rst` low after 5 bytes of word 1 in a 2-word load.
  - Required: all outputs are 0 immediately and no write occurs.
  - Required: a fresh `start` with `load_len`=1 writes addr 0 with the new 9 bytes only.
- `start` pulsed during RECV → ignored: the latched length and the address sequence are unchanged, and there is no `err`.
